demux_dist: RTL and testbench

DEMUX_DIST -- requirements
Module: demux_dist

---
 rtl/demux_dist.sv | 115 +++++++++++
 tb/tb_demux_dist.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_dist.sv
// Ten-slot word distributor: words are steered into registered slots either by
// an auto-incrementing pointer or by an explicit select, and collected as frames.
module demux_dist #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       sel,
  input  logic             auto_mode,
  input  logic             clear,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] demux_out_0,
  output logic [WIDTH-1:0] demux_out_1,
  output logic [WIDTH-1:0] demux_out_2,
  output logic [WIDTH-1:0] demux_out_3,
  output logic [WIDTH-1:0] demux_out_4,
  output logic [WIDTH-1:0] demux_out_5,
  output logic [WIDTH-1:0] demux_out_6,
  output logic [WIDTH-1:0] demux_out_7,
  output logic [WIDTH-1:0] demux_out_8,
  output logic [WIDTH-1:0] demux_out_9,
  output logic [9:0]       slot_valid,
  output logic             frame_done,
  output logic             err_sel
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  localparam int         NSLOT = 10;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] slot_q [NSLOT];
  logic [WIDTH-1:0] slot_d [NSLOT];
  logic [9:0]       valid_q, valid_d;
  logic [3:0]       ptr_q, ptr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign in_ready = (state_q == FILL);

  // Priority is clear, then frame_ack, then a data write; writes only land in FILL.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (clear) begin
      state_d = FILL;
      for (int i = 0; i < NSLOT; i++) slot_d[i] = '0;
      valid_d = '0;
      ptr_d   = '0;
    end else if (state_q == FULL) begin
      if (frame_ack) begin
        state_d = FILL;
        valid_d = '0;
        ptr_d   = '0;
      end
    end else if (in_valid) begin
      if (auto_mode) begin
        slot_d[ptr_q]  = in_data;
        valid_d[ptr_q] = 1'b1;
        ptr_d          = (ptr_q == 4'd9) ? 4'd0 : ptr_q + 4'd1;
      end else if (sel < 7'd10) begin
        slot_d[sel[3:0]]  = in_data;
        valid_d[sel[3:0]] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      // The write that completes the frame flips to FULL on the same edge.
      if (valid_d == 10'h3FF) begin
        state_d = FULL;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign demux_out_0 = slot_q[0];
  assign demux_out_1 = slot_q[1];
  assign demux_out_2 = slot_q[2];
  assign demux_out_3 = slot_q[3];
  assign demux_out_4 = slot_q[4];
  assign demux_out_5 = slot_q[5];
  assign demux_out_6 = slot_q[6];
  assign demux_out_7 = slot_q[7];
  assign demux_out_8 = slot_q[8];
  assign demux_out_9 = slot_q[9];
  assign slot_valid  = valid_q;
  assign frame_done  = done_q;
  assign err_sel     = err_q;

endmodule

// File: tb/tb_demux_dist.sv
// Directed bench for demux_dist: auto fill, FULL hold/ack, addressed errors,
// overwrite, clear-over-ack priority and mid-frame reset.
module tb_demux_dist;

  logic        clk = 1'b0;
  logic        rst, in_valid, auto_mode, clear, frame_ack;
  logic [15:0] in_data;
  logic [6:0]  sel;
  logic        in_ready, frame_done, err_sel;
  logic [9:0]  slot_valid;
  logic [15:0] outs [10];
  logic [15:0] model [10];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  demux_dist #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .auto_mode(auto_mode), .clear(clear),
    .frame_ack(frame_ack),
    .demux_out_0(outs[0]), .demux_out_1(outs[1]), .demux_out_2(outs[2]),
    .demux_out_3(outs[3]), .demux_out_4(outs[4]), .demux_out_5(outs[5]),
    .demux_out_6(outs[6]), .demux_out_7(outs[7]), .demux_out_8(outs[8]),
    .demux_out_9(outs[9]),
    .slot_valid(slot_valid), .frame_done(frame_done), .err_sel(err_sel)
  );

  // Advance one rising edge and settle before anything is sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSlots(input string tag);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("%s out_%0d", tag, i), {16'h0, outs[i]}, {16'h0, model[i]});
  endtask

  task automatic clearModel();
    for (int i = 0; i < 10; i++) model[i] = 16'h0;
  endtask

  task automatic autoWrite(input logic [15:0] data, input int slot);
    auto_mode = 1'b1; in_valid = 1'b1; in_data = data;
    applyStimulus();
    in_valid = 1'b0;
    model[slot] = data;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; auto_mode = 1'b1; clear = 1'b0;
    frame_ack = 1'b0; in_data = 16'h0; sel = 7'd0;
    clearModel();
    #2;
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("reset slot_valid", {22'h0, slot_valid}, 32'h0);
    checkOutput("reset frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("reset err_sel", {31'h0, err_sel}, 32'h0);
    checkSlots("reset");

    // Ten back-to-back auto words; frame_done only with the tenth.
    auto_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'h0100 + 16'(i);
      applyStimulus();
      model[i] = 16'h0100 + 16'(i);
      checkOutput($sformatf("fill%0d slot_valid", i), {22'h0, slot_valid},
                  32'((1 << (i + 1)) - 1));
      checkOutput($sformatf("fill%0d frame_done", i), {31'h0, frame_done},
                  (i == 9) ? 32'h1 : 32'h0);
    end
    checkOutput("full in_ready", {31'h0, in_ready}, 32'h0);
    checkSlots("fill");

    in_data = 16'hDEAD;
    applyStimulus();
    checkOutput("full hold frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("full hold slot_valid", {22'h0, slot_valid}, 32'h3FF);
    checkOutput("full hold err_sel", {31'h0, err_sel}, 32'h0);
    checkSlots("full hold");

    // Ack while in_valid is still high: the word must not land.
    frame_ack = 1'b1;
    applyStimulus();
    frame_ack = 1'b0; in_valid = 1'b0;
    checkOutput("ack slot_valid", {22'h0, slot_valid}, 32'h0);
    checkOutput("ack in_ready", {31'h0, in_ready}, 32'h1);
    checkSlots("ack");

    frame_ack = 1'b1;
    applyStimulus();
    frame_ack = 1'b0;
    checkOutput("ack in FILL ignored", {22'h0, slot_valid}, 32'h0);

    autoWrite(16'h0200, 0);
    checkOutput("ptr reset slot_valid", {22'h0, slot_valid}, 32'h001);
    checkOutput("ptr reset out_0", {16'h0, outs[0]}, 32'h0200);

    // Addressed out-of-range select is dropped with a one-cycle error.
    auto_mode = 1'b0; in_valid = 1'b1; sel = 7'd12; in_data = 16'hBEEF;
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("bad sel err_sel", {31'h0, err_sel}, 32'h1);
    checkOutput("bad sel slot_valid", {22'h0, slot_valid}, 32'h001);
    checkSlots("bad sel");
    applyStimulus();
    checkOutput("err_sel pulse end", {31'h0, err_sel}, 32'h0);

    in_valid = 1'b1; sel = 7'd3; in_data = 16'h1234;
    applyStimulus();
    in_valid = 1'b0;
    model[3] = 16'h1234;
    checkOutput("sel3 slot_valid", {22'h0, slot_valid}, 32'h009);
    checkOutput("sel3 err_sel", {31'h0, err_sel}, 32'h0);
    checkSlots("sel3");

    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    clearModel();
    checkOutput("clear slot_valid", {22'h0, slot_valid}, 32'h0);
    checkSlots("clear");

    in_valid = 1'b1; sel = 7'd5; in_data = 16'hAAAA;
    applyStimulus();
    in_data = 16'h5555;
    applyStimulus();
    in_valid = 1'b0;
    model[5] = 16'h5555;
    checkOutput("overwrite slot_valid", {22'h0, slot_valid}, 32'h020);
    checkOutput("overwrite frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("overwrite err_sel", {31'h0, err_sel}, 32'h0);
    checkOutput("overwrite out_5", {16'h0, outs[5]}, 32'h5555);

    // Auto fill from pointer 0; slot 5 is already valid and gets overwritten.
    for (int i = 0; i < 10; i++) autoWrite(16'h0300 + 16'(i), i);
    checkOutput("refill frame_done", {31'h0, frame_done}, 32'h1);
    checkOutput("refill in_ready", {31'h0, in_ready}, 32'h0);
    checkSlots("refill");

    clear = 1'b1; frame_ack = 1'b1;
    applyStimulus();
    clear = 1'b0; frame_ack = 1'b0;
    clearModel();
    checkOutput("clear+ack slot_valid", {22'h0, slot_valid}, 32'h0);
    checkOutput("clear+ack in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("clear+ack frame_done", {31'h0, frame_done}, 32'h0);
    checkSlots("clear+ack");

    for (int i = 0; i < 4; i++) autoWrite(16'h0400 + 16'(i), i);
    checkOutput("pre-reset slot_valid", {22'h0, slot_valid}, 32'h00F);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    clearModel();
    checkOutput("mid reset slot_valid", {22'h0, slot_valid}, 32'h0);
    checkOutput("mid reset in_ready", {31'h0, in_ready}, 32'h1);
    checkSlots("mid reset");
    autoWrite(16'h0500, 0);
    checkOutput("post reset slot_valid", {22'h0, slot_valid}, 32'h001);
    checkSlots("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
